// File: rtl/uvmt_cv32e40x_rchk_pkg.sv
// Shared types and the rchk parity helper for the OBI rchk checker.
// calc_rchk: per-byte parity of rdata plus err parity, MSB first.
package uvmt_cv32e40x_rchk_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARMED    = 2'd1,
    FAILED   = 2'd2
  } rchk_chk_state_e;

  function automatic logic [4:0] calc_rchk(
    input logic [31:0] rdata,
    input logic        err
  );
    return {err,
            ^rdata[31:24],
            ^rdata[23:16],
            ^rdata[15:8],
            ^rdata[7:0]};
  endfunction

endpackage

// File: rtl/uvmt_cv32e40x_obi_attr_fifo.sv
// In-order 1-bit attribute FIFO for outstanding OBI transactions.
// Ports: push_i/data_i write tail, pop_i reads head (data_o),
// full_o/empty_o/count_o report occupancy. Push while full is
// accepted only together with a pop; pop while empty is ignored.
module uvmt_cv32e40x_obi_attr_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          data_i,
  input  logic          pop_i,
  output logic          data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  // a full FIFO still takes a push when the head leaves this cycle
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= inc(wptr_q);
      end
      if (do_pop) rptr_q <= inc(rptr_q);
      if (do_push && !do_pop) cnt_q <= cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/uvmt_cv32e40x_rchk_checker.sv
// Passive OBI response rchk checker: tracks integrity per request,
// recomputes rchk per response, flags/counts/latches mismatches.
module uvmt_cv32e40x_rchk_checker
  import uvmt_cv32e40x_rchk_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter bit          CHECK_NONINT    = 1'b1,
  parameter bit          STOP_ON_ERROR   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic                 req_i,
  input  logic                 gnt_i,
  input  logic                 integrity_i,
  input  logic                 rvalid_i,
  input  logic [31:0]          rdata_i,
  input  logic                 err_i,
  input  logic [4:0]           rchk_i,
  output logic                 rchk_err_o,
  output logic [4:0]           exp_rchk_o,
  output logic                 fail_o,
  output logic                 overflow_o,
  output logic                 underflow_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic [CNT_WIDTH-1:0] resp_cnt_o,
  output logic [CNT_WIDTH-1:0] mismatch_cnt_o
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  rchk_chk_state_e state_q, state_d;

  logic                 push, head, full, empty;
  logic                 pop_vld, check, mismatch;
  logic [4:0]           exp_rchk;
  logic                 rchk_err_q, fail_q, ovf_q, unf_q;
  logic [4:0]           exp_q;
  logic [CNT_WIDTH-1:0] resp_cnt_q, mis_cnt_q;

  assign push    = req_i && gnt_i;
  assign pop_vld = rvalid_i && !empty;

  uvmt_cv32e40x_obi_attr_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CW    (OW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (integrity_i),
    .pop_i   (rvalid_i),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (outstanding_o)
  );

  assign exp_rchk = calc_rchk(rdata_i, err_i);
  assign check    = (state_q == ARMED) && pop_vld;
  // non-integrity responses carry fully inverted rchk
  assign mismatch = check &&
    (head ? (rchk_i != exp_rchk)
          : (CHECK_NONINT && (rchk_i != ~exp_rchk)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      DISABLED: if (enable_i) state_d = ARMED;
      ARMED: begin
        if (mismatch && STOP_ON_ERROR) state_d = FAILED;
        else if (!enable_i)           state_d = DISABLED;
      end
      FAILED:  state_d = FAILED;
      default: state_d = DISABLED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= DISABLED;
      rchk_err_q <= 1'b0;
      fail_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      exp_q      <= '0;
      resp_cnt_q <= '0;
      mis_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rchk_err_q <= mismatch;
      fail_q     <= (state_d == FAILED);
      if (push && full && !rvalid_i) ovf_q <= 1'b1;
      if (rvalid_i && empty)         unf_q <= 1'b1;
      if (check) exp_q <= exp_rchk;
      if (check && resp_cnt_q != '1)
        resp_cnt_q <= resp_cnt_q + CNT_WIDTH'(1);
      if (mismatch && mis_cnt_q != '1)
        mis_cnt_q <= mis_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign rchk_err_o     = rchk_err_q;
  assign exp_rchk_o     = exp_q;
  assign fail_o         = fail_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;
  assign resp_cnt_o     = resp_cnt_q;
  assign mismatch_cnt_o = mis_cnt_q;

endmodule
